reed_divider: RTL

- Shared sequential unsigned divider serving the Speed block's division requests.
- Requester drives `dividerbus = {dividend, divisor}` plus a one-cycle `start` strobe.
- Divider returns a quotient on `dividerres` and reports status on `dividercontrol = {busy, ready}`.
- Restoring radix-2 algorithm, one quotient bit per clock; sits between Speed and any other requester through a single bus.

---
 rtl/reed_divider_if.sv | 17 +
 rtl/reed_divider.sv | 125 ++++++++++++
 2 files changed

// File: rtl/reed_divider_if.sv
// Request/response bus between a requester (Speed) and the shared divider.
// DIVIDER_REMAINDER_EN adds the dividerrem response signal.
interface reed_divider_if #(parameter int WIDTH = 16);
  logic                 start;
  logic [3*WIDTH-1:0]   dividerbus;
  logic [WIDTH-1:0]     dividerres;
  logic [1:0]           dividercontrol;
`ifdef DIVIDER_REMAINDER_EN
  logic [WIDTH-1:0]     dividerrem;

  modport master (output start, dividerbus, input dividerres, dividercontrol, dividerrem);
  modport slave  (input start, dividerbus, output dividerres, dividercontrol, dividerrem);
`else
  modport master (output start, dividerbus, input dividerres, dividercontrol);
  modport slave  (input start, dividerbus, output dividerres, dividercontrol);
`endif
endinterface

// File: rtl/reed_divider.sv
// Shared restoring radix-2 unsigned divider, one quotient bit per clock.
// DIVIDER_REMAINDER_EN exposes the final remainder on dividerrem.
module reed_divider #(
  parameter int WIDTH = 16
) (
  input  logic           clk,
  input  logic           rst,
  reed_divider_if.slave  bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   dvd_q, dvd_d;    // low dividend bits, quotient shifts in at LSB
  logic [WIDTH:0]     rem_q, rem_d;
  logic [WIDTH-1:0]   dsr_q, dsr_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               busy_q, busy_d;
  logic               ready_q, ready_d;
`ifdef DIVIDER_REMAINDER_EN
  logic [WIDTH-1:0]   remo_q, remo_d;
`endif

  logic [2*WIDTH-1:0] req_dvd;
  logic [WIDTH-1:0]   req_dsr;
  logic               req_ovf;
  logic [WIDTH:0]     trial, diff;
  logic               ge;

  assign req_dvd = bus.dividerbus[3*WIDTH-1:WIDTH];
  assign req_dsr = bus.dividerbus[WIDTH-1:0];
  // quotient fits in WIDTH bits only when the high dividend half is below the divisor
  assign req_ovf = (req_dsr == '0) || (req_dvd[2*WIDTH-1:WIDTH] >= req_dsr);

  assign trial = {rem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
  assign ge    = rem_q[WIDTH] | (trial >= {1'b0, dsr_q});
  assign diff  = trial - {1'b0, dsr_q};

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    rem_d   = rem_q;
    dsr_d   = dsr_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    busy_d  = busy_q;
    ready_d = ready_q;
`ifdef DIVIDER_REMAINDER_EN
    remo_d  = remo_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (state_q == DONE && busy_q) begin
          // overflow / divide-by-zero result, one cycle after acceptance
          res_d   = '1;
          busy_d  = 1'b0;
          ready_d = 1'b1;
`ifdef DIVIDER_REMAINDER_EN
          remo_d  = dvd_q;
`endif
        end else if (bus.start) begin
          dsr_d   = req_dsr;
          dvd_d   = req_dvd[WIDTH-1:0];
          rem_d   = {1'b0, req_dvd[2*WIDTH-1:WIDTH]};
          cnt_d   = '0;
          busy_d  = 1'b1;
          ready_d = 1'b0;
          state_d = req_ovf ? DONE : RUN;
        end
      end
      RUN: begin
        rem_d = ge ? diff : trial;
        dvd_d = {dvd_q[WIDTH-2:0], ge};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH-1)) begin
          res_d   = dvd_d;
          busy_d  = 1'b0;
          ready_d = 1'b1;
          cnt_d   = '0;
          state_d = DONE;
`ifdef DIVIDER_REMAINDER_EN
          remo_d  = rem_d[WIDTH-1:0];
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      rem_q   <= '0;
      dsr_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
`ifdef DIVIDER_REMAINDER_EN
      remo_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      rem_q   <= rem_d;
      dsr_q   <= dsr_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
`ifdef DIVIDER_REMAINDER_EN
      remo_q  <= remo_d;
`endif
    end
  end

  assign bus.dividerres     = res_q;
  assign bus.dividercontrol = {busy_q, ready_q};
`ifdef DIVIDER_REMAINDER_EN
  assign bus.dividerrem     = remo_q;
`endif
endmodule
